// File: rtl/si7021_pkg.sv
// Shared command codes, user-register reset value and FSM state encoding for the Si7021 I2C target.
package si7021_pkg;

    localparam logic [7:0] CMD_MEAS_T   = 8'hF3;
    localparam logic [7:0] CMD_MEAS_RH  = 8'hF5;
    localparam logic [7:0] CMD_READ_T   = 8'hE0;
    localparam logic [7:0] CMD_WR_USER  = 8'hE6;
    localparam logic [7:0] USER_REG_RST = 8'h3A;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_CMD,
        ST_CMD_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_TX_BYTE,
        ST_RX_MACK,
        ST_WAIT_STOP
    } state_t;

    function automatic logic cmd_known(input logic [7:0] c);
        return (c == CMD_MEAS_T) || (c == CMD_MEAS_RH) || (c == CMD_READ_T) || (c == CMD_WR_USER);
    endfunction

endpackage

// File: rtl/crc8_0x31.sv
// Combinational CRC-8, polynomial 0x31, init 0x00, over a 16-bit word MSB first.
module crc8_0x31 (
    input  logic [15:0] data,
    output logic [7:0]  crc
);

    always_comb begin
        crc = 8'h00;
        for (int i = 15; i >= 0; i--) begin
            if (crc[7] ^ data[i]) crc = {crc[6:0], 1'b0} ^ 8'h31;
            else                  crc = {crc[6:0], 1'b0};
        end
    end

endmodule

// File: rtl/si7021_i2c_target.sv
// Si7021-style I2C target: measurement commands, user register, 2-byte result read.
// Optional CRC third byte is built when SI7021_CRC_EN is defined.
module si7021_i2c_target
    import si7021_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h40,
    parameter int         CONV_CYCLES = 1000
) (
    input  logic        clk100MHz,
    input  logic        rst_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_out,
    output logic        sda_en,
    input  logic [15:0] temp_data,
    input  logic [15:0] rh_data,
    output logic [7:0]  user_reg,
    output logic        busy
);

    localparam int CW = $clog2(CONV_CYCLES + 1);

    logic [1:0]    scl_sync, sda_sync;
    logic          scl_d, sda_d;
    logic          scl_rise, scl_fall, start_det, stop_det;
    state_t        state;
    logic [7:0]    shreg, tx_sh, cmd;
    logic [3:0]    bit_cnt;
    logic [1:0]    byte_idx;
    logic          is_read, conv_rh, result_valid;
    logic [15:0]   result, temp_snap;
    logic [CW-1:0] conv_cnt;

    assign sda_out = 1'b0;

    // Bus lines idle high, so the synchronizers reset to 1 to avoid a false START.
    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_rise  = scl_sync[1] & ~scl_d;
    assign scl_fall  = ~scl_sync[1] & scl_d;
    assign start_det = scl_sync[1] & scl_d & sda_d & ~sda_sync[1];
    assign stop_det  = scl_sync[1] & scl_d & ~sda_d & sda_sync[1];

`ifdef SI7021_CRC_EN
    logic [7:0] crc;
    crc8_0x31 u_crc (
        .data (result),
        .crc  (crc)
    );
`endif

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            sda_en       <= 1'b0;
            shreg        <= 8'h00;
            tx_sh        <= 8'h00;
            cmd          <= 8'h00;
            bit_cnt      <= 4'd0;
            byte_idx     <= 2'd0;
            is_read      <= 1'b0;
            conv_rh      <= 1'b0;
            busy         <= 1'b0;
            conv_cnt     <= '0;
            result       <= 16'h0000;
            result_valid <= 1'b0;
            temp_snap    <= 16'h0000;
            user_reg     <= USER_REG_RST;
        end else begin
            if (busy) begin
                if (conv_cnt == CW'(1)) begin
                    busy         <= 1'b0;
                    result       <= conv_rh ? rh_data : temp_data;
                    result_valid <= 1'b1;
                    temp_snap    <= temp_data;
                end else begin
                    conv_cnt <= conv_cnt - CW'(1);
                end
            end

            if (scl_rise) begin
                shreg   <= {shreg[6:0], sda_sync[1]};
                bit_cnt <= bit_cnt + 4'd1;
            end

            // sda_en only moves on an SCL falling edge so SDA never changes while SCL is high.
            if (start_det) begin
                state   <= ST_ADDR;
                bit_cnt <= 4'd0;
            end else if (stop_det) begin
                state <= ST_IDLE;
            end else if (scl_fall) begin
                sda_en <= 1'b0;
                case (state)
                    ST_ADDR: if (bit_cnt == 4'd8) begin
                        bit_cnt <= 4'd0;
                        if (shreg[7:1] != DEV_ADDR) begin
                            state <= ST_WAIT_STOP;
                        end else if (!shreg[0]) begin
                            is_read <= 1'b0;
                            sda_en  <= 1'b1;
                            state   <= ST_ADDR_ACK;
                        end else if (busy || !result_valid) begin
                            state <= ST_WAIT_STOP;
                        end else begin
                            is_read <= 1'b1;
                            sda_en  <= 1'b1;
                            state   <= ST_ADDR_ACK;
                        end
                    end
                    ST_ADDR_ACK: begin
                        bit_cnt <= 4'd0;
                        if (is_read) begin
                            byte_idx <= 2'd0;
                            sda_en   <= ~result[15];
                            tx_sh    <= {result[14:8], 1'b0};
                            state    <= ST_TX_BYTE;
                        end else begin
                            state <= ST_CMD;
                        end
                    end
                    ST_CMD: if (bit_cnt == 4'd8) begin
                        bit_cnt <= 4'd0;
                        cmd     <= shreg;
                        if (cmd_known(shreg)) begin
                            sda_en <= 1'b1;
                            state  <= ST_CMD_ACK;
                            if ((shreg == CMD_MEAS_T || shreg == CMD_MEAS_RH) && !busy) begin
                                busy     <= 1'b1;
                                conv_cnt <= CW'(CONV_CYCLES);
                                conv_rh  <= (shreg == CMD_MEAS_RH);
                            end
                            if (shreg == CMD_READ_T) begin
                                result       <= temp_snap;
                                result_valid <= 1'b1;
                            end
                        end else begin
                            state <= ST_WAIT_STOP;
                        end
                    end
                    ST_CMD_ACK: begin
                        bit_cnt <= 4'd0;
                        state   <= (cmd == CMD_WR_USER) ? ST_WDATA : ST_WAIT_STOP;
                    end
                    ST_WDATA: if (bit_cnt == 4'd8) begin
                        bit_cnt  <= 4'd0;
                        sda_en   <= 1'b1;
                        user_reg <= shreg;
                        state    <= ST_WDATA_ACK;
                    end
                    ST_WDATA_ACK: state <= ST_WAIT_STOP;
                    ST_TX_BYTE: begin
                        if (bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            state   <= ST_RX_MACK;
                        end else begin
                            sda_en <= ~tx_sh[7];
                            tx_sh  <= {tx_sh[6:0], 1'b0};
                        end
                    end
                    // shreg[0] holds the master's ACK bit (0 = ACK) sampled on the last rise.
                    ST_RX_MACK: begin
                        bit_cnt <= 4'd0;
                        if (!shreg[0] && byte_idx == 2'd0) begin
                            byte_idx <= 2'd1;
                            sda_en   <= ~result[7];
                            tx_sh    <= {result[6:0], 1'b0};
                            state    <= ST_TX_BYTE;
`ifdef SI7021_CRC_EN
                        end else if (!shreg[0] && byte_idx == 2'd1) begin
                            byte_idx <= 2'd2;
                            sda_en   <= ~crc[7];
                            tx_sh    <= {crc[6:0], 1'b0};
                            state    <= ST_TX_BYTE;
`endif
                        end else begin
                            state <= ST_WAIT_STOP;
                            if (shreg[0] && byte_idx != 2'd0) result_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_si7021_i2c_target.sv
// Bench for si7021_i2c_target: bit-banged I2C master, reference model and queued scoreboard.
module tb_si7021_i2c_target;

    localparam int CONV = 1000;
    localparam int Q    = 12;

    typedef struct {
        string name;
        int    val;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_out, sda_en, busy;
    logic [15:0] temp_data = 16'h0000;
    logic [15:0] rh_data = 16'h0000;
    logic [7:0]  user_reg;
    logic        sda_bus;

    assign sda_bus = sda_m & (sda_en ? sda_out : 1'b1);

    si7021_i2c_target #(.DEV_ADDR(7'h40), .CONV_CYCLES(CONV)) dut (
        .clk100MHz (clk),
        .rst_n     (rst_n),
        .scl_in    (scl_m),
        .sda_in    (sda_bus),
        .sda_out   (sda_out),
        .sda_en    (sda_en),
        .temp_data (temp_data),
        .rh_data   (rh_data),
        .user_reg  (user_reg),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad = 0;
    item_t bus_exp[$];
    item_t bus_obs[$];
    int    busy_exp[$];

    // Reference model state
    bit          m_busy, m_pend_rh, m_valid;
    logic [15:0] m_result, m_snap;
    logic [7:0]  m_user;

    bit quiet = 1'b0;
    int quiet_hits = 0;

    function automatic void expect_bus(input string n, input int v);
        item_t it;
        it.name = n;
        it.val  = v;
        bus_exp.push_back(it);
    endfunction

    function automatic void observe_bus(input string n, input int v);
        item_t it;
        it.name = n;
        it.val  = v;
        bus_obs.push_back(it);
    endfunction

    function automatic void model_reset();
        m_busy   = 1'b0;
        m_pend_rh = 1'b0;
        m_valid  = 1'b0;
        m_result = 16'h0000;
        m_snap   = 16'h0000;
        m_user   = 8'h3A;
        busy_exp.delete();
    endfunction

    function automatic logic [7:0] crc8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] c;
        logic [7:0] bytes [2];
        bytes[0] = a;
        bytes[1] = b;
        c = 8'h00;
        for (int k = 0; k < 2; k++) begin
            c = c ^ bytes[k];
            for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
        end
        return c;
    endfunction

    function automatic bit is_known(input logic [7:0] c);
        return c inside {8'hF3, 8'hF5, 8'hE0, 8'hE6};
    endfunction

    // Bus scoreboard: pairs each observation with the oldest expectation.
    initial begin : bus_monitor
        item_t o, e;
        forever begin
            @(negedge clk);
            while (bus_obs.size() != 0) begin
                o = bus_obs.pop_front();
                total++;
                if (bus_exp.size() == 0) begin
                    bad++;
                    $display("FAIL %s: got %0h, nothing was expected", o.name, o.val);
                end else begin
                    e = bus_exp.pop_front();
                    if (e.name != o.name || e.val != o.val) begin
                        bad++;
                        $display("FAIL %s: got %0h (%s), required %0h", e.name, o.val, o.name, e.val);
                    end
                end
            end
        end
    end

    // Busy pulse monitor: every completed (non-reset) pulse is checked against an expected length.
    int  bcnt = 0;
    bit  bprev = 1'b0;
    initial begin : busy_monitor
        forever begin
            @(negedge clk);
            if (bprev && !busy) begin
                if (rst_n) begin
                    total++;
                    if (busy_exp.size() == 0) begin
                        bad++;
                        $display("FAIL busy_len: pulse of %0d cycles, none expected", bcnt);
                    end else if (busy_exp[0] != bcnt) begin
                        bad++;
                        $display("FAIL busy_len: got %0d cycles, required %0d", bcnt, busy_exp[0]);
                        void'(busy_exp.pop_front());
                    end else begin
                        void'(busy_exp.pop_front());
                    end
                end
                bcnt = 0;
            end
            if (busy) bcnt++;
            if (!rst_n) bcnt = 0;
            bprev = busy;
            if (quiet && sda_en) quiet_hits++;
        end
    end

    initial begin : watchdog
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: run did not complete within cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic qd();
        repeat (Q) @(posedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; qd();
        scl_m = 1'b1; qd();
        sda_m = 1'b0; qd();
        scl_m = 1'b0; qd();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; qd();
        scl_m = 1'b1; qd();
        sda_m = 1'b1; qd();
    endtask

    task automatic write_bit(input bit b);
        sda_m = b; qd();
        scl_m = 1'b1; qd(); qd();
        scl_m = 1'b0; qd();
    endtask

    task automatic read_bit(output bit b);
        sda_m = 1'b1; qd();
        scl_m = 1'b1; qd();
        #1 b = sda_bus;
        qd();
        scl_m = 1'b0; qd();
    endtask

    task automatic write_byte(input logic [7:0] d, output bit ack);
        bit b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input bit mack);
        bit b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~mack);
    endtask

    task automatic do_cmd(input logic [7:0] c, input logic [7:0] wd);
        bit ack;
        i2c_start();
        write_byte(8'h80, ack);
        expect_bus("addr_w_ack", 1);
        observe_bus("addr_w_ack", ack);
        write_byte(c, ack);
        expect_bus("cmd_ack", is_known(c));
        observe_bus("cmd_ack", ack);
        if ((c == 8'hF3 || c == 8'hF5) && !m_busy) begin
            m_busy    = 1'b1;
            m_pend_rh = (c == 8'hF5);
            busy_exp.push_back(CONV);
        end
        if (c == 8'hE0) begin
            m_result = m_snap;
            m_valid  = 1'b1;
        end
        if (c == 8'hE6) begin
            write_byte(wd, ack);
            expect_bus("wdata_ack", 1);
            observe_bus("wdata_ack", ack);
            m_user = wd;
            #1;
            expect_bus("user_reg", m_user);
            observe_bus("user_reg", user_reg);
        end
        i2c_stop();
    endtask

    task automatic wait_conv();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        expect_bus("conv_done", 1);
        observe_bus("conv_done", !busy);
        if (m_busy) begin
            m_result = m_pend_rh ? rh_data : temp_data;
            m_snap   = temp_data;
            m_valid  = 1'b1;
            m_busy   = 1'b0;
        end
    endtask

    task automatic do_read(input bit third);
        bit ack, ok;
        logic [7:0] d;
        ok = !m_busy && m_valid;
        i2c_start();
        write_byte(8'h81, ack);
        expect_bus("addr_r_ack", ok);
        observe_bus("addr_r_ack", ack);
        if (ack && ok) begin
            read_byte(d, 1'b1);
            expect_bus("rd_msb", m_result[15:8]);
            observe_bus("rd_msb", d);
            read_byte(d, third);
            expect_bus("rd_lsb", m_result[7:0]);
            observe_bus("rd_lsb", d);
            if (third) begin
                read_byte(d, 1'b0);
`ifdef SI7021_CRC_EN
                expect_bus("rd_crc", crc8(m_result[15:8], m_result[7:0]));
                m_valid = 1'b0;
`else
                expect_bus("rd_crc", 8'hFF);
`endif
                observe_bus("rd_crc", d);
            end else begin
                m_valid = 1'b0;
            end
        end
        i2c_stop();
    endtask

    initial begin : main
        bit ack;
        logic [7:0] c;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        expect_bus("rst_sda_en", 0);   observe_bus("rst_sda_en", sda_en);
        expect_bus("rst_busy", 0);     observe_bus("rst_busy", busy);
        expect_bus("rst_user_reg", 8'h3A); observe_bus("rst_user_reg", user_reg);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Unknown command is NACKed and leaves no result to read
        do_cmd(8'h55, 8'h00);
        do_read(1'b0);

        // Foreign address: target never drives SDA
        quiet_hits = 0;
        quiet = 1'b1;
        i2c_start();
        write_byte(8'h82, ack);
        expect_bus("foreign_ack", 0); observe_bus("foreign_ack", ack);
        write_byte(8'hF3, ack);
        expect_bus("foreign_byte_ack", 0); observe_bus("foreign_byte_ack", ack);
        i2c_stop();
        quiet = 1'b0;
        expect_bus("foreign_quiet", 0); observe_bus("foreign_quiet", quiet_hits);

        do_cmd(8'hE6, 8'h3B);

        // Temperature conversion, early read refused, then full read
        temp_data = 16'h664C;
        rh_data   = 16'h1234;
        do_cmd(8'hF3, 8'h00);
        do_read(1'b0);
        wait_conv();
        do_read(1'b1);
        do_read(1'b0);
        do_read(1'b0);

        // Reset while the target drives a data bit
        temp_data = 16'h0F0F;
        do_cmd(8'hF3, 8'h00);
        wait_conv();
        i2c_start();
        write_byte(8'h81, ack);
        expect_bus("tx_addr_ack", 1); observe_bus("tx_addr_ack", ack);
        sda_m = 1'b1; qd();
        scl_m = 1'b1; qd();
        #1;
        expect_bus("tx_drive", 1); observe_bus("tx_drive", sda_en);
        #2 rst_n = 1'b0;
        #2;
        expect_bus("midtx_rst_sda_en", 0); observe_bus("midtx_rst_sda_en", sda_en);
        expect_bus("midtx_rst_busy", 0);   observe_bus("midtx_rst_busy", busy);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        scl_m = 1'b0; qd();
        i2c_stop();
        #1;
        expect_bus("post_rst_user_reg", 8'h3A); observe_bus("post_rst_user_reg", user_reg);
        do_read(1'b0);

        // Reset aborts a running conversion
        rh_data = 16'hABCD;
        do_cmd(8'hF5, 8'h00);
        repeat (50) @(posedge clk);
        #2 rst_n = 1'b0;
        #2;
        expect_bus("conv_abort_busy", 0); observe_bus("conv_abort_busy", busy);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        repeat (5) @(posedge clk);
        do_read(1'b0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 8; i++) begin
            temp_data = 16'($urandom_range(0, 65535));
            rh_data   = 16'($urandom_range(0, 65535));
            case ($urandom_range(0, 5))
                0: begin
                    do_cmd(8'hF3, 8'h00);
                    if ($urandom_range(0, 1) == 1) do_read(1'b0);
                    wait_conv();
                    do_read(1'($urandom_range(0, 1)));
                end
                1: begin
                    do_cmd(8'hF5, 8'h00);
                    wait_conv();
                    do_read(1'($urandom_range(0, 1)));
                end
                2: begin
                    do_cmd(8'hE0, 8'h00);
                    do_read(1'($urandom_range(0, 1)));
                end
                3: do_cmd(8'hE6, 8'($urandom_range(0, 255)));
                4: begin
                    c = 8'($urandom_range(0, 255));
                    while (is_known(c)) c = c + 8'd1;
                    do_cmd(c, 8'h00);
                    do_read(1'b0);
                end
                default: do_read(1'($urandom_range(0, 1)));
            endcase
        end

        repeat (10) @(posedge clk);
        while (bus_exp.size() != 0) begin
            item_t e;
            e = bus_exp.pop_front();
            total++;
            bad++;
            $display("FAIL %s: no observation, required %0h", e.name, e.val);
        end
        while (busy_exp.size() != 0) begin
            total++;
            bad++;
            $display("FAIL busy_len: no pulse seen, required %0d", busy_exp.pop_front());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/si7021_i2c_target.md
SI7021_I2C_TARGET -- requirements
Module: si7021_i2c_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h40, the 7-bit target address it answers to.
REQ-002 SHALL have parameter CONV_CYCLES, default 1000, the measurement busy time in clk100MHz cycles; values below 1 are illegal.
REQ-003 SHALL have port clk100MHz, input, 1 bit: the single clock, 100 MHz, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port scl_in, input, 1 bit: bus SCL, asynchronous to the clock.
REQ-006 SHALL have port sda_in, input, 1 bit: bus SDA, asynchronous to the clock.
REQ-007 SHALL have port sda_out, output, 1 bit: held constant 0 (open-drain low).
REQ-008 SHALL have port sda_en, output, 1 bit: 1 pulls SDA low; 0 releases it.
REQ-009 SHALL have port temp_data, input, 16 bits: raw temperature code, sampled at the end of a conversion.
REQ-010 SHALL have port rh_data, input, 16 bits: raw humidity code, sampled at the end of a conversion.
REQ-011 SHALL have port user_reg, output, 8 bits: last value written with command 0xE6; reset value 8'h3A.
REQ-012 SHALL have port busy, output, 1 bit: high while a conversion is in progress.

Function
REQ-013 SHALL pass scl_in and sda_in through two-flop synchronizers, then detect edges on the synchronized copies.
REQ-014 SHALL detect START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high; both SHALL be valid in any state.
REQ-015 SHALL sample SDA on SCL rising edges, and change sda_en only on the first clk100MHz cycle after an SCL falling edge.
REQ-016 SHALL implement the states IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, WDATA, WDATA_ACK, TX_BYTE, RX_MACK and WAIT_STOP.
REQ-017 SHALL move to ADDR on START or repeated START, and shift 8 bits into ADDR, MSB first.
REQ-018 SHALL, on an address mismatch, go to WAIT_STOP with sda_en=0 until the next START or STOP.
REQ-019 SHALL, on a matching write address, ACK and then receive the command byte.
REQ-020 SHALL ACK commands 0xF3, 0xF5, 0xE0 and 0xE6, and NACK any other command before going to WAIT_STOP.
REQ-021 SHALL, on 0xF3 or 0xF5 with busy=0, set busy and load a counter with CONV_CYCLES; at terminal count it SHALL latch temp_data or rh_data into result, set result_valid and clear busy.
REQ-022 SHALL, on 0xF3 or 0xF5 received with busy=1, ACK the byte and ignore the command.
REQ-023 SHALL, on 0xE0, load result from the last temperature snapshot (0 after reset) and set result_valid; busy is not asserted.
REQ-024 SHALL, on 0xE6, ACK the next data byte and write it into user_reg at that ACK.
REQ-025 SHALL, on a matching read address, NACK if busy=1 or result_valid=0; otherwise ACK and enter TX_BYTE.
REQ-026 SHALL make the NACK in REQ-025 the only form of clock stretching: it never holds SCL.
REQ-027 SHALL, in TX_BYTE, shift result[15:8] and then result[7:0] MSB first, with sda_en = ~bit.
REQ-028 SHALL, in RX_MACK, continue to the next byte on a master ACK, and release the bus and go to WAIT_STOP on a master NACK.
REQ-029 SHALL clear result_valid after the LSB byte is NACKed.
REQ-030 SHALL let a conversion keep running across START and STOP.

Reset
REQ-031 SHALL, while rst_n=0, hold sda_en=0, busy=0, user_reg=8'h3A, result=0, result_valid=0, with the state in IDLE.
REQ-032 SHALL, when rst_n is asserted mid-transfer, release the bus immediately and abort any conversion.

Configuration
REQ-033 SHALL, with SI7021_CRC_EN defined, send a third byte after an ACKed LSB: the CRC-8 (poly 0x31, init 0x00) over MSB and LSB.
REQ-034 SHALL, without SI7021_CRC_EN, treat a master ACK after the LSB as end of data, with sda_en=0 (bus reads 0xFF) until STOP or START.

Structure
REQ-035 SHALL take its command codes (0xF3, 0xF5, 0xE0, 0xE6), reset user_reg value and state encoding from the shared package si7021_pkg.
REQ-036 SHALL, with SI7021_CRC_EN, instantiate the combinational sub-module crc8_0x31.

Verification
REQ-037 SHALL verify: write 0x80 -> ACK; command 0xF3 -> ACK, busy=1 for 1000 cycles; read 0x81 before that -> NACK; read after -> ACK, then 0x66 and 0x4C with temp_data=16'h664C.
REQ-038 SHALL verify: address 0x82 -> sda_en stays 0 for the whole transfer.
REQ-039 SHALL verify: command 0x55 -> NACK; a following read -> NACK (result_valid=0).
REQ-040 SHALL verify: write 0xE6 then 0x3B -> user_reg=8'h3B after the data ACK.
REQ-041 SHALL verify: rst_n pulsed low during TX_BYTE -> sda_en=0 within 1 cycle, busy=0.
REQ-042 SHALL verify: with SI7021_CRC_EN and data 0x664C, a master ACK after the LSB -> third byte equals the CRC-8 of 0x66,0x4C.
